// File: rtl/aq_axi_lite_pkg.sv
`default_nettype none
// ============================================================================
// Module      : aq_axi_lite_pkg
// Description : Shared state encoding, AXI response codes and default
//               cache/prot attributes for the AXI4-Lite local-bus master.
// Revision    : 1.0 - initial release
// ============================================================================
package aq_axi_lite_pkg;

    // FSM state encoding
    typedef logic [2:0] state_t;

    localparam state_t c_ST_IDLE    = 3'd0;
    localparam state_t c_ST_WR_REQ  = 3'd1;
    localparam state_t c_ST_WR_RESP = 3'd2;
    localparam state_t c_ST_RD_REQ  = 3'd3;
    localparam state_t c_ST_RD_DATA = 3'd4;
    localparam state_t c_ST_RELEASE = 3'd5;

    // AXI response codes
    localparam logic [1:0] c_RESP_OKAY   = 2'b00;
    localparam logic [1:0] c_RESP_EXOKAY = 2'b01;
    localparam logic [1:0] c_RESP_SLVERR = 2'b10;
    localparam logic [1:0] c_RESP_DECERR = 2'b11;

    // Default transaction attributes
    localparam logic [3:0] c_AXI_CACHE_DEF = 4'b0011;
    localparam logic [2:0] c_AXI_PROT_DEF  = 3'b000;

    // Anything other than OKAY is reported as an error, EXOKAY included,
    // since a single-word initiator never issues exclusive accesses.
    function automatic logic resp_is_err(input logic [1:0] resp);
        return (resp != c_RESP_OKAY);
    endfunction

endpackage
`default_nettype wire

// File: rtl/aq_axi_lite_master.sv
`default_nettype none
// ============================================================================
// Module      : aq_axi_lite_master
// Description : Converts single-word local-bus requests (CS/RNW/ACK) into
//               AXI4-Lite read or write transactions, one at a time.
// Revision    : 1.0 - initial release
// ============================================================================
module aq_axi_lite_master
    import aq_axi_lite_pkg::*;
#(
    parameter int         ADDR_W    = 16,
    parameter logic [3:0] AXI_CACHE = c_AXI_CACHE_DEF,
    parameter logic [2:0] AXI_PROT  = c_AXI_PROT_DEF
)(
    input  logic              CLK,
    input  logic              RST,

    // Local bus
    input  logic              LOCAL_CS,
    input  logic              LOCAL_RNW,
    input  logic [ADDR_W-1:0] LOCAL_ADDR,
    input  logic [3:0]        LOCAL_BE,
    input  logic [31:0]       LOCAL_WDATA,
    output logic              LOCAL_ACK,
    output logic [31:0]       LOCAL_RDATA,
    output logic              LOCAL_ERR,
    output logic              LOCAL_BUSY,

    // AXI write address channel
    output logic [ADDR_W-1:0] M_AXI_AWADDR,
    output logic [3:0]        M_AXI_AWCACHE,
    output logic [2:0]        M_AXI_AWPROT,
    output logic              M_AXI_AWVALID,
    input  logic              M_AXI_AWREADY,

    // AXI write data channel
    output logic [31:0]       M_AXI_WDATA,
    output logic [3:0]        M_AXI_WSTRB,
    output logic              M_AXI_WVALID,
    input  logic              M_AXI_WREADY,

    // AXI write response channel
    input  logic              M_AXI_BVALID,
    input  logic [1:0]        M_AXI_BRESP,
    output logic              M_AXI_BREADY,

    // AXI read address channel
    output logic [ADDR_W-1:0] M_AXI_ARADDR,
    output logic [3:0]        M_AXI_ARCACHE,
    output logic [2:0]        M_AXI_ARPROT,
    output logic              M_AXI_ARVALID,
    input  logic              M_AXI_ARREADY,

    // AXI read data channel
    input  logic [31:0]       M_AXI_RDATA,
    input  logic [1:0]        M_AXI_RRESP,
    input  logic              M_AXI_RVALID,
    output logic              M_AXI_RREADY
);

    state_t              r_state;
    logic [ADDR_W-1:0]   r_addr;
    logic [3:0]          r_be;
    logic [31:0]         r_wdata;
    logic [31:0]         r_rdata;
    logic                r_awvalid;
    logic                r_wvalid;
    logic                r_bready;
    logic                r_arvalid;
    logic                r_rready;
    logic                r_ack;
    logic                r_err;

    logic                w_aw_beat;
    logic                w_w_beat;
    logic                w_ar_beat;
    logic                w_aw_done;
    logic                w_w_done;

    // Handshake decode; a channel counts as done once its VALID has dropped
    // after an earlier beat, so AW and W may finish in either order.
    always_comb begin
        w_aw_beat = r_awvalid & M_AXI_AWREADY;
        w_w_beat  = r_wvalid  & M_AXI_WREADY;
        w_ar_beat = r_arvalid & M_AXI_ARREADY;
        w_aw_done = ~r_awvalid | w_aw_beat;
        w_w_done  = ~r_wvalid  | w_w_beat;
    end

    // Transaction FSM with registered VALID/READY outputs and request latches
    always_ff @(posedge CLK) begin
        if (RST) begin
            r_state   <= c_ST_IDLE;
            r_addr    <= '0;
            r_be      <= '0;
            r_wdata   <= '0;
            r_rdata   <= '0;
            r_awvalid <= 1'b0;
            r_wvalid  <= 1'b0;
            r_bready  <= 1'b0;
            r_arvalid <= 1'b0;
            r_rready  <= 1'b0;
            r_ack     <= 1'b0;
            r_err     <= 1'b0;
        end else begin
            r_ack <= 1'b0;
            case (r_state)
                c_ST_IDLE: begin
                    if (LOCAL_CS) begin
                        r_addr  <= LOCAL_ADDR;
                        r_be    <= LOCAL_BE;
                        r_wdata <= LOCAL_WDATA;
                        if (LOCAL_RNW) begin
                            r_arvalid <= 1'b1;
                            r_state   <= c_ST_RD_REQ;
                        end else begin
                            r_awvalid <= 1'b1;
                            r_wvalid  <= 1'b1;
                            r_state   <= c_ST_WR_REQ;
                        end
                    end
                end

                c_ST_WR_REQ: begin
                    if (w_aw_beat) begin
                        r_awvalid <= 1'b0;
                    end
                    if (w_w_beat) begin
                        r_wvalid <= 1'b0;
                    end
                    if (w_aw_done && w_w_done) begin
                        r_bready <= 1'b1;
                        r_state  <= c_ST_WR_RESP;
                    end
                end

                c_ST_WR_RESP: begin
                    if (M_AXI_BVALID) begin
                        r_bready <= 1'b0;
                        r_err    <= resp_is_err(M_AXI_BRESP);
                        r_ack    <= 1'b1;
                        r_state  <= c_ST_RELEASE;
                    end
                end

                c_ST_RD_REQ: begin
                    if (w_ar_beat) begin
                        r_arvalid <= 1'b0;
                        r_rready  <= 1'b1;
                        r_state   <= c_ST_RD_DATA;
                    end
                end

                c_ST_RD_DATA: begin
                    if (M_AXI_RVALID) begin
                        r_rready <= 1'b0;
                        r_rdata  <= M_AXI_RDATA;
                        r_err    <= resp_is_err(M_AXI_RRESP);
                        r_ack    <= 1'b1;
                        r_state  <= c_ST_RELEASE;
                    end
                end

                // Wait for the requester to drop CS so a held CS cannot
                // launch a second transaction.
                c_ST_RELEASE: begin
                    if (!LOCAL_CS) begin
                        r_state <= c_ST_IDLE;
                    end
                end

                default: begin
                    r_state <= c_ST_IDLE;
                end
            endcase
        end
    end

    assign LOCAL_ACK     = r_ack;
    assign LOCAL_RDATA   = r_rdata;
    assign LOCAL_ERR     = r_err;
    assign LOCAL_BUSY    = (r_state != c_ST_IDLE);

    assign M_AXI_AWADDR  = r_addr;
    assign M_AXI_AWCACHE = AXI_CACHE;
    assign M_AXI_AWPROT  = AXI_PROT;
    assign M_AXI_AWVALID = r_awvalid;

    assign M_AXI_WDATA   = r_wdata;
    assign M_AXI_WSTRB   = r_be;
    assign M_AXI_WVALID  = r_wvalid;

    assign M_AXI_BREADY  = r_bready;

    assign M_AXI_ARADDR  = r_addr;
    assign M_AXI_ARCACHE = AXI_CACHE;
    assign M_AXI_ARPROT  = AXI_PROT;
    assign M_AXI_ARVALID = r_arvalid;

    assign M_AXI_RREADY  = r_rready;

endmodule
`default_nettype wire

// File: tb/tb_aq_axi_lite_master.sv
`default_nettype none
// ============================================================================
// Module      : tb_aq_axi_lite_master
// Description : Scoreboard bench for aq_axi_lite_master with a delay-
//               configurable AXI4-Lite slave model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_aq_axi_lite_master;

    localparam int c_ADDR_W = 16;

    logic                clk = 1'b0;
    logic                rst;
    logic                local_cs;
    logic                local_rnw;
    logic [c_ADDR_W-1:0] local_addr;
    logic [3:0]          local_be;
    logic [31:0]         local_wdata;
    logic                local_ack;
    logic [31:0]         local_rdata;
    logic                local_err;
    logic                local_busy;
    logic [c_ADDR_W-1:0] awaddr;
    logic [3:0]          awcache;
    logic [2:0]          awprot;
    logic                awvalid;
    logic                awready;
    logic [31:0]         wdata;
    logic [3:0]          wstrb;
    logic                wvalid;
    logic                wready;
    logic                bvalid;
    logic [1:0]          bresp;
    logic                bready;
    logic [c_ADDR_W-1:0] araddr;
    logic [3:0]          arcache;
    logic [2:0]          arprot;
    logic                arvalid;
    logic                arready;
    logic [31:0]         rdata;
    logic [1:0]          rresp;
    logic                rvalid;
    logic                rready;

    always #5 clk = ~clk;

    aq_axi_lite_master #(.ADDR_W(c_ADDR_W)) u_dut (
        .CLK           (clk),
        .RST           (rst),
        .LOCAL_CS      (local_cs),
        .LOCAL_RNW     (local_rnw),
        .LOCAL_ADDR    (local_addr),
        .LOCAL_BE      (local_be),
        .LOCAL_WDATA   (local_wdata),
        .LOCAL_ACK     (local_ack),
        .LOCAL_RDATA   (local_rdata),
        .LOCAL_ERR     (local_err),
        .LOCAL_BUSY    (local_busy),
        .M_AXI_AWADDR  (awaddr),
        .M_AXI_AWCACHE (awcache),
        .M_AXI_AWPROT  (awprot),
        .M_AXI_AWVALID (awvalid),
        .M_AXI_AWREADY (awready),
        .M_AXI_WDATA   (wdata),
        .M_AXI_WSTRB   (wstrb),
        .M_AXI_WVALID  (wvalid),
        .M_AXI_WREADY  (wready),
        .M_AXI_BVALID  (bvalid),
        .M_AXI_BRESP   (bresp),
        .M_AXI_BREADY  (bready),
        .M_AXI_ARADDR  (araddr),
        .M_AXI_ARCACHE (arcache),
        .M_AXI_ARPROT  (arprot),
        .M_AXI_ARVALID (arvalid),
        .M_AXI_ARREADY (arready),
        .M_AXI_RDATA   (rdata),
        .M_AXI_RRESP   (rresp),
        .M_AXI_RVALID  (rvalid),
        .M_AXI_RREADY  (rready)
    );

    // ---------------- slave model configuration ----------------
    int          cfg_aw_dly, cfg_w_dly, cfg_b_dly, cfg_ar_dly, cfg_r_dly;
    logic [1:0]  cfg_bresp, cfg_rresp;
    logic [31:0] cfg_rdata;

    int   sl_aw_wait, sl_w_wait, sl_ar_wait, sl_b_cnt, sl_r_cnt;
    logic sl_got_aw, sl_got_w, sl_b_pend, sl_r_pend;

    assign awready = awvalid && (sl_aw_wait >= cfg_aw_dly);
    assign wready  = wvalid  && (sl_w_wait  >= cfg_w_dly);
    assign arready = arvalid && (sl_ar_wait >= cfg_ar_dly);
    assign bvalid  = sl_b_pend && (sl_b_cnt == 0);
    assign rvalid  = sl_r_pend && (sl_r_cnt == 0);
    assign bresp   = cfg_bresp;
    assign rresp   = cfg_rresp;
    assign rdata   = cfg_rdata;

    // Slave: READY after a programmable number of VALID cycles, response
    // after a programmable delay once the request beats are in.
    always @(posedge clk) begin
        if (rst) begin
            sl_aw_wait <= 0; sl_w_wait <= 0; sl_ar_wait <= 0;
            sl_b_cnt   <= 0; sl_r_cnt  <= 0;
            sl_got_aw  <= 1'b0; sl_got_w <= 1'b0;
            sl_b_pend  <= 1'b0; sl_r_pend <= 1'b0;
        end else begin
            if (awvalid && awready) begin
                sl_aw_wait <= 0; sl_got_aw <= 1'b1;
            end else if (awvalid) begin
                sl_aw_wait <= sl_aw_wait + 1;
            end
            if (wvalid && wready) begin
                sl_w_wait <= 0; sl_got_w <= 1'b1;
            end else if (wvalid) begin
                sl_w_wait <= sl_w_wait + 1;
            end
            if ((sl_got_aw || (awvalid && awready)) && (sl_got_w || (wvalid && wready))) begin
                sl_got_aw <= 1'b0; sl_got_w <= 1'b0;
                sl_b_pend <= 1'b1; sl_b_cnt <= cfg_b_dly;
            end else if (sl_b_pend && sl_b_cnt > 0) begin
                sl_b_cnt <= sl_b_cnt - 1;
            end else if (bvalid && bready) begin
                sl_b_pend <= 1'b0;
            end
            if (arvalid && arready) begin
                sl_ar_wait <= 0; sl_r_pend <= 1'b1; sl_r_cnt <= cfg_r_dly;
            end else begin
                if (arvalid) sl_ar_wait <= sl_ar_wait + 1;
                if (sl_r_pend && sl_r_cnt > 0) sl_r_cnt <= sl_r_cnt - 1;
                else if (rvalid && rready) sl_r_pend <= 1'b0;
            end
        end
    end

    // ---------------- scoreboard ----------------
    typedef struct {
        bit          rnw;
        bit          err;
        logic [31:0] rdata;
        int          lat;
    } ack_exp_t;

    logic [c_ADDR_W-1:0] exp_aw[$];
    logic [c_ADDR_W-1:0] exp_ar[$];
    logic [35:0]         exp_w[$];
    ack_exp_t            exp_ack[$];

    int n_vec = 0, n_err = 0;
    int cyc = 0, start_cyc = 0;
    int aw_hi, w_hi, ar_hi, b_beats, ack_cnt = 0, stab_err = 0;
    logic [c_ADDR_W-1:0] cur_addr;
    logic [31:0]         cur_wdata;
    logic [3:0]          cur_be;

    task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Advance one cycle and sample everything on the falling edge
    task automatic tick();
        ack_exp_t e;
        @(negedge clk);
        cyc++;
        if (awvalid) begin
            aw_hi++;
            if (awaddr !== cur_addr) stab_err++;
        end
        if (wvalid) begin
            w_hi++;
            if (wdata !== cur_wdata || wstrb !== cur_be) stab_err++;
        end
        if (arvalid) begin
            ar_hi++;
            if (araddr !== cur_addr) stab_err++;
        end
        if (awvalid && awready) begin
            if (exp_aw.size() == 0) check_eq("aw_unexpected", 1, 0);
            else check_eq("awaddr", 64'(awaddr), 64'(exp_aw.pop_front()));
        end
        if (wvalid && wready) begin
            if (exp_w.size() == 0) check_eq("w_unexpected", 1, 0);
            else check_eq("wstrb_wdata", 64'({wstrb, wdata}), 64'(exp_w.pop_front()));
        end
        if (arvalid && arready) begin
            if (exp_ar.size() == 0) check_eq("ar_unexpected", 1, 0);
            else check_eq("araddr", 64'(araddr), 64'(exp_ar.pop_front()));
        end
        if (bvalid && bready) b_beats++;
        if (local_ack) begin
            ack_cnt++;
            if (exp_ack.size() == 0) begin
                check_eq("ack_unexpected", 1, 0);
            end else begin
                e = exp_ack.pop_front();
                check_eq("ack_err", 64'(local_err), 64'(e.err));
                check_eq("ack_latency", 64'(cyc - start_cyc), 64'(e.lat));
                if (e.rnw) check_eq("ack_rdata", 64'(local_rdata), 64'(e.rdata));
            end
        end
    endtask

    // One local-bus request, optionally holding CS after ACK
    task automatic do_req(input bit rnw, input logic [c_ADDR_W-1:0] addr,
                          input logic [31:0] wd, input logic [3:0] be,
                          input bit e_err, input logic [31:0] e_rdata,
                          input int e_lat, input int hold);
        int n;
        int got;
        ack_exp_t e;
        cur_addr = addr; cur_wdata = wd; cur_be = be;
        if (rnw) exp_ar.push_back(addr);
        else begin
            exp_aw.push_back(addr);
            exp_w.push_back({be, wd});
        end
        e.rnw = rnw; e.err = e_err; e.rdata = e_rdata; e.lat = e_lat;
        exp_ack.push_back(e);
        aw_hi = 0; w_hi = 0; ar_hi = 0; b_beats = 0;
        local_cs = 1'b1; local_rnw = rnw; local_addr = addr;
        local_wdata = wd; local_be = be;
        start_cyc = cyc;
        got = ack_cnt;
        n = 0;
        while (ack_cnt == got && n < 40) begin
            tick();
            n++;
        end
        if (ack_cnt == got) check_eq("ack_timeout", 0, 1);
        if (hold > 0) begin
            aw_hi = 0; ar_hi = 0;
            repeat (hold) tick();
            check_eq("hold_no_new_valid", 64'(aw_hi + ar_hi), 0);
            check_eq("hold_busy", 64'(local_busy), 1);
        end
        local_cs = 1'b0;
        tick();
        check_eq("busy_after_cs_drop", 64'(local_busy), 0);
    endtask

    initial begin
        rst = 1'b1;
        local_cs = 1'b0; local_rnw = 1'b0; local_addr = '0;
        local_be = '0; local_wdata = '0;
        cfg_aw_dly = 0; cfg_w_dly = 0; cfg_b_dly = 0; cfg_ar_dly = 0; cfg_r_dly = 0;
        cfg_bresp = 2'b00; cfg_rresp = 2'b00; cfg_rdata = 32'h0;
        cur_addr = '0; cur_wdata = '0; cur_be = '0;
        repeat (3) tick();

        // Reset state
        check_eq("rst_ctrl", 64'({awvalid, wvalid, bready, arvalid, rready,
                                  local_ack, local_err, local_busy}), 0);
        check_eq("rst_rdata", 64'(local_rdata), 0);
        check_eq("rst_addr_data", 64'({awaddr, araddr, wdata, wstrb}), 0);
        check_eq("cache_prot", 64'({awcache, awprot, arcache, arprot}), 64'(14'b0011_000_0011_000));
        rst = 1'b0;
        tick();

        // Zero-wait write
        do_req(1'b0, 16'h0010, 32'h0000_1234, 4'hF, 1'b0, 32'h0, 3, 0);
        check_eq("wr0_aw_cycles", 64'(aw_hi), 1);
        check_eq("wr0_w_cycles", 64'(w_hi), 1);
        check_eq("wr0_b_beats", 64'(b_beats), 1);

        // AWREADY three cycles late, W immediate
        cfg_aw_dly = 3;
        do_req(1'b0, 16'h0024, 32'hA5A5_0F0F, 4'h3, 1'b0, 32'h0, 6, 0);
        check_eq("wr1_aw_cycles", 64'(aw_hi), 4);
        check_eq("wr1_w_cycles", 64'(w_hi), 1);
        check_eq("wr1_b_beats", 64'(b_beats), 1);

        // W late, AW early, plus a slow B
        cfg_aw_dly = 0; cfg_w_dly = 2; cfg_b_dly = 1;
        do_req(1'b0, 16'h0030, 32'hCAFE_F00D, 4'hC, 1'b0, 32'h0, 6, 0);
        check_eq("wr2_aw_cycles", 64'(aw_hi), 1);
        check_eq("wr2_w_cycles", 64'(w_hi), 3);
        cfg_w_dly = 0; cfg_b_dly = 0;

        // Read with RVALID five cycles late
        cfg_r_dly = 5; cfg_rdata = 32'h1234_5678;
        do_req(1'b1, 16'h0100, 32'h0, 4'h0, 1'b0, 32'h1234_5678, 8, 0);
        check_eq("rd0_ar_cycles", 64'(ar_hi), 1);

        // Read with ARREADY two cycles late
        cfg_r_dly = 0; cfg_ar_dly = 2; cfg_rdata = 32'h0BAD_C0DE;
        do_req(1'b1, 16'h0204, 32'h0, 4'h0, 1'b0, 32'h0BAD_C0DE, 5, 0);
        check_eq("rd1_ar_cycles", 64'(ar_hi), 3);
        cfg_ar_dly = 0;

        // SLVERR read keeps returned data, then OKAY write clears ERR
        cfg_rresp = 2'b10; cfg_rdata = 32'hDEAD_BEEF;
        do_req(1'b1, 16'h0300, 32'h0, 4'h0, 1'b1, 32'hDEAD_BEEF, 3, 0);
        cfg_rresp = 2'b00;
        do_req(1'b0, 16'h0304, 32'h1111_2222, 4'hF, 1'b0, 32'h0, 3, 0);

        // DECERR write, then CS held ten cycles after ACK on a clean read
        cfg_bresp = 2'b11;
        do_req(1'b0, 16'h0308, 32'h3333_4444, 4'h1, 1'b1, 32'h0, 3, 0);
        cfg_bresp = 2'b00; cfg_rdata = 32'h5555_AAAA;
        do_req(1'b1, 16'h030C, 32'h0, 4'h0, 1'b0, 32'h5555_AAAA, 3, 10);
        check_eq("rdata_held", 64'(local_rdata), 64'(32'h5555_AAAA));

        // Reset while ARVALID is pending
        cfg_ar_dly = 20;
        cur_addr = 16'h0400;
        local_cs = 1'b1; local_rnw = 1'b1; local_addr = 16'h0400;
        tick(); tick();
        check_eq("ar_pending", 64'(arvalid), 1);
        rst = 1'b1; local_cs = 1'b0;
        tick();
        check_eq("midrst_valids", 64'({arvalid, rready, awvalid, wvalid, bready}), 0);
        check_eq("midrst_busy", 64'(local_busy), 0);
        check_eq("midrst_rdata", 64'(local_rdata), 0);
        rst = 1'b0; cfg_ar_dly = 0;
        begin
            int acks_before;
            acks_before = ack_cnt;
            repeat (5) tick();
            check_eq("midrst_no_ack", 64'(ack_cnt - acks_before), 0);
        end

        // Recovery after reset
        do_req(1'b0, 16'h0500, 32'h7777_8888, 4'hF, 1'b0, 32'h0, 3, 0);

        check_eq("valid_payload_stable", 64'(stab_err), 0);
        check_eq("scoreboard_empty", 64'(exp_aw.size() + exp_w.size() + exp_ar.size() + exp_ack.size()), 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire
